nds_fb_arbiter: RTL and testbench
=================================

Name: nds_fb_arbiter

Overview:
- Shares the single-port NDS frame-buffer BRAM (256x192 words, 18-bit RGB666) between two requesters.
- The VGA scan-out reader has absolute priority.
- The NDS capture writer is buffered in a small FIFO and drained into BRAM on cycles with no read.
- Sits between the capture front end, the VGA pixel path and the BRAM port, all in the pixel_clk domain.

Parameters:
- ADDR_W, 16, BRAM word-address width.
- DATA_W, 18, pixel width ({r,g,b} at 6 bits each).
- FB_WORDS, 49152, valid address range 0..FB_WORDS-1 (256*192).
- FIFO_DEPTH, 4, write FIFO entries; must be a power of 2 and at least 2.

Ports:
- pixel_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request from the VGA path, sampled every cycle.
- rd_addr  in  ADDR_W  read word address.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_W  read pixel.
- wr_valid  in  1  capture write offered.
- wr_ready  out  1  FIFO can accept the offered write.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write pixel.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_din  out  DATA_W  BRAM write data.
- bram_dout  in  DATA_W  BRAM read data; 1-cycle read latency.
- clr_status  in  1  clears the sticky status flags and the drop counter.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- wr_overflow  out  1  sticky: a write was offered while wr_ready was 0.
- addr_err  out  1  sticky: an out-of-range read or write was seen.
- drop_cnt  out  16  count of dropped writes, saturating at 16'hFFFF.

Behaviour:
- Reset (reset_n low, asynchronous): every output is 0 except wr_ready, which is 1. The FIFO is empty and the op stage is idle. Anything in flight is discarded; no BRAM access is issued after reset asserts.
- Handshakes:
  - wr_ready = (fifo_level != FIFO_DEPTH).
  - A push happens when wr_valid && wr_ready.
  - wr_valid && !wr_ready sets wr_overflow and increments drop_cnt. The write is lost.
  - A push with wr_addr >= FB_WORDS is discarded: it is not stored and it sets addr_err.
  - A push and a pop in the same cycle are both allowed when the FIFO is full, but wr_ready is still 0 that cycle (no combinational ready-from-pop path).
- Arbitration (each cycle, into the registered op stage):
  - If rd_req, load a READ op; the FIFO does not pop.
  - Else if the FIFO is non-empty, pop the head and load a WRITE op.
  - Else the stage is idle.
- Op stage drives the BRAM the next cycle:
  - READ: bram_en=1, bram_we=0, bram_addr=rd_addr as sampled.
  - WRITE: bram_en=1, bram_we=1, bram_addr and bram_din from the FIFO head.
  - Idle: bram_en=0 and bram_we=0.
- Read latency:
  - rd_req is sampled at edge t; bram_en is high in cycle t+1; bram_dout is captured at edge t+2; rd_valid/rd_data are high in cycle t+2.
  - rd_valid is high exactly 2 cycles after rd_req, back-to-back at full throughput with no bubbles.
  - Out-of-range read (rd_addr >= FB_WORDS): no BRAM access (bram_en=0 for that slot), rd_valid still pulses on schedule with rd_data=0, and addr_err is set.
- Write ordering: writes reach BRAM in FIFO order. A read of an address whose write is still in the FIFO returns the old BRAM content. The VGA path tolerates this; no forwarding is done.
- Starvation: continuous rd_req blocks all writes. During a 256-cycle active line the FIFO fills and excess writes drop (they are counted). Writes drain in blanking at 1 per cycle.
- Status clearing:
  - clr_status clears wr_overflow, addr_err and drop_cnt on the next edge.
  - If a new error occurs in the same cycle as clr_status, the error wins: the flag stays set and drop_cnt becomes 1.
- Wrap-around: the FIFO uses pointers with 1 extra bit to tell full from empty. drop_cnt never wraps.

Decomposition:
- Package nds_fb_pkg:
  - NDS_H=256, NDS_V=192, FB_WORDS=NDS_H*NDS_V.
  - typedef pixel_t as a packed struct of r, g, b, 6 bits each.
  - typedef fb_addr_t as logic [15:0].
  - enum op_e = {OP_IDLE, OP_READ, OP_WRITE}.
- Sub-module nds_wr_fifo: synchronous FIFO carrying {addr, data}, with push, pop, full, empty and level.
- The arbiter top holds the op stage, the read-valid pipeline and the status logic.

Test Plan:
- Reset, then 4 writes (addr 0..3, data 18'h00001..18'h00004) with rd_req=0 -> bram_we pulses 4 consecutive cycles in order; fifo_level ends at 0.
- Preload addr 100=18'h3F000, then rd_req for 3 consecutive cycles at addr 100 -> rd_valid high for exactly 3 cycles starting 2 cycles after the first rd_req, rd_data=18'h3F000 each cycle.
- rd_req held for 20 cycles while wr_valid is held high (addr 10..) -> 4 writes accepted, wr_ready drops, wr_overflow=1, drop_cnt=16; after rd_req falls the 4 writes drain in 4 cycles.
- rd_addr=49152 and wr_addr=50000 -> no bram_en for either; rd_valid pulses with rd_data=0; addr_err=1; fifo_level unchanged.
- clr_status in the same cycle as an overflowing write -> wr_overflow stays 1 and drop_cnt=1.
- reset_n asserted mid-drain with fifo_level=3 -> all outputs 0 and wr_ready=1 immediately; no bram_we after release until a new push.

Source files
------------

// File: rtl/nds_fb_pkg.sv
// Shared types and geometry for the NDS frame-buffer arbiter slice.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package nds_fb_pkg;

    // Native NDS screen geometry; the frame buffer holds one word per pixel.
    localparam int NDS_H    = 256;
    localparam int NDS_V    = 192;
    localparam int FB_WORDS = NDS_H * NDS_V;

    // One RGB666 pixel as stored in the frame buffer.
    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } pixel_t;

    // Frame-buffer word address.
    typedef logic [15:0] fb_addr_t;

    // What the registered op stage drives onto the BRAM port this cycle.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

endpackage

// File: rtl/nds_wr_fifo.sv
// Small synchronous FIFO holding {addr, data} capture writes.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module nds_wr_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     pixel_clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LVL);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being overwritten.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage array: written on push, no reset needed for the data itself.
    always_ff @(posedge pixel_clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nds_fb_arbiter.sv
// Shares the single-port frame-buffer BRAM between VGA reads and buffered capture writes.
// Latency: rd_valid/rd_data exactly 2 cycles after rd_req; writes reach BRAM >= 2 cycles after push.
// Backpressure: reads never stall; writes stall in the FIFO while reads run, drop when it is full.
module nds_fb_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 18,
    parameter int FB_WORDS   = nds_fb_pkg::FB_WORDS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          pixel_clk,
    input  logic                          reset_n,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          bram_en,
    output logic                          bram_we,
    output logic [ADDR_W-1:0]             bram_addr,
    output logic [DATA_W-1:0]             bram_din,
    input  logic [DATA_W-1:0]             bram_dout,
    input  logic                          clr_status,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          wr_overflow,
    output logic                          addr_err,
    output logic [15:0]                   drop_cnt
);

    import nds_fb_pkg::*;

    localparam int ENT_W = ADDR_W + DATA_W;
    // One extra bit so the limit is representable even for a full address space.
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W + 1)'(FB_WORDS);

    // ---------------------------------------------------------------
    // Write side: range check, FIFO and drop detection
    // ---------------------------------------------------------------
    logic              rd_oor;
    logic              wr_oor;
    logic              wr_accept;
    logic              wr_drop;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign rd_oor    = ({1'b0, rd_addr} >= FB_LIMIT);
    assign wr_oor    = ({1'b0, wr_addr} >= FB_LIMIT);
    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign wr_ready  = !fifo_full;
    assign wr_accept = wr_valid && wr_ready;
    assign wr_drop   = wr_valid && !wr_ready;
    // Out-of-range writes are handshaken but never stored.
    assign fifo_push = wr_accept && !wr_oor;

    assign {head_addr, head_data} = fifo_head;

    nds_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .din       ({wr_addr, wr_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // ---------------------------------------------------------------
    // Op stage: one BRAM access per cycle, reads first
    // ---------------------------------------------------------------
    op_e               op_q;
    op_e               op_d;
    logic [ADDR_W-1:0] op_addr_q;
    logic [ADDR_W-1:0] op_addr_d;
    logic [DATA_W-1:0] op_din_q;
    logic [DATA_W-1:0] op_din_d;

    // Choose next op: a read always wins; an out-of-range read leaves the slot idle.
    always_comb begin
        op_d      = OP_IDLE;
        op_addr_d = '0;
        op_din_d  = '0;
        fifo_pop  = 1'b0;
        if (rd_req) begin
            if (!rd_oor) begin
                op_d      = OP_READ;
                op_addr_d = rd_addr;
            end
        end else if (!fifo_empty) begin
            op_d      = OP_WRITE;
            op_addr_d = head_addr;
            op_din_d  = head_data;
            fifo_pop  = 1'b1;
        end
    end

    // Op stage register; reset drops any access in flight.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= OP_IDLE;
            op_addr_q <= '0;
            op_din_q  <= '0;
        end else begin
            op_q      <= op_d;
            op_addr_q <= op_addr_d;
            op_din_q  <= op_din_d;
        end
    end

    assign bram_en   = (op_q != OP_IDLE);
    assign bram_we   = (op_q == OP_WRITE);
    assign bram_addr = op_addr_q;
    assign bram_din  = op_din_q;

    // ---------------------------------------------------------------
    // Read-valid pipeline: tracks each rd_req through the BRAM latency
    // ---------------------------------------------------------------
    logic rd_pend_q;
    logic rd_pend_oor_q;
    logic rd_valid_q;
    logic rd_zero_q;

    // Two-stage valid shift; out-of-range reads keep their slot but return zero.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q     <= 1'b0;
            rd_pend_oor_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_zero_q     <= 1'b0;
        end else begin
            rd_pend_q     <= rd_req;
            rd_pend_oor_q <= rd_req && rd_oor;
            rd_valid_q    <= rd_pend_q;
            rd_zero_q     <= rd_pend_oor_q;
        end
    end

    // BRAM output register is used directly in the valid cycle.
    assign rd_valid = rd_valid_q;
    assign rd_data  = (rd_valid_q && !rd_zero_q) ? bram_dout : '0;

    // ---------------------------------------------------------------
    // Sticky status and drop counter
    // ---------------------------------------------------------------
    logic        addr_evt;
    logic        wr_overflow_q;
    logic        addr_err_q;
    logic [15:0] drop_cnt_q;

    assign addr_evt = (rd_req && rd_oor) || (wr_accept && wr_oor);

    // New errors take precedence over a same-cycle clear.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_overflow_q <= 1'b0;
            addr_err_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            if (wr_drop) begin
                wr_overflow_q <= 1'b1;
                if (clr_status) begin
                    drop_cnt_q <= 16'd1;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end else if (clr_status) begin
                wr_overflow_q <= 1'b0;
                drop_cnt_q    <= '0;
            end
            if (addr_evt) begin
                addr_err_q <= 1'b1;
            end else if (clr_status) begin
                addr_err_q <= 1'b0;
            end
        end
    end

    assign wr_overflow = wr_overflow_q;
    assign addr_err    = addr_err_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_nds_fb_arbiter.sv
// Directed bench for nds_fb_arbiter with a queue-based reference model and a BRAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nds_fb_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 18;
    localparam int FBW   = 49152;
    localparam int DEPTH = 4;

    logic          pixel_clk = 1'b0;
    logic          reset_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          clr_status;
    logic [2:0]    fifo_level;
    logic          wr_overflow;
    logic          addr_err;
    logic [15:0]   drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 pixel_clk = ~pixel_clk;

    nds_fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .clr_status(clr_status), .fifo_level(fifo_level),
        .wr_overflow(wr_overflow), .addr_err(addr_err), .drop_cnt(drop_cnt)
    );

    // BRAM: single port, registered read output.
    logic [DW-1:0] bram_mem [0:65535];
    always @(posedge pixel_clk) begin
        if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_din;
            else         bram_dout <= bram_mem[bram_addr];
        end
    end

    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] ref_mem [0:65535];
    logic          m_en = 0, m_we = 0;
    logic [AW-1:0] m_addr = 0;
    logic [DW-1:0] m_din = 0;
    logic          m_rv1 = 0, m_rv2 = 0;
    logic [DW-1:0] m_rd1 = 0, m_rd2 = 0;
    logic          m_ovf = 0, m_aerr = 0;
    int            m_drop = 0;
    logic          pend_w = 0;
    logic [AW-1:0] pend_a = 0;
    logic [DW-1:0] pend_d = 0;

    task automatic model_reset();
        mq.delete();
        m_en = 0; m_we = 0; m_addr = 0; m_din = 0;
        m_rv1 = 0; m_rv2 = 0; m_rd1 = 0; m_rd2 = 0;
        m_ovf = 0; m_aerr = 0; m_drop = 0;
        pend_w = 0;
    endtask

    task automatic model_step();
        logic ready, drop, aev;
        ent_t e;
        // a write chosen last edge lands in memory at this edge
        if (pend_w) ref_mem[pend_a] = pend_d;
        pend_w = 0;
        ready = (mq.size() != DEPTH);
        drop  = wr_valid && !ready;
        aev   = (rd_req && int'(rd_addr) >= FBW) || (wr_valid && ready && int'(wr_addr) >= FBW);
        m_en = 0; m_we = 0; m_addr = 0; m_din = 0;
        if (rd_req) begin
            if (int'(rd_addr) < FBW) begin m_en = 1; m_addr = rd_addr; end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_en = 1; m_we = 1; m_addr = e.a; m_din = e.d;
            pend_w = 1; pend_a = e.a; pend_d = e.d;
        end
        if (wr_valid && ready && int'(wr_addr) < FBW) begin
            e.a = wr_addr; e.d = wr_data;
            mq.push_back(e);
        end
        m_rv2 = m_rv1; m_rd2 = m_rd1;
        m_rv1 = rd_req;
        m_rd1 = (rd_req && int'(rd_addr) < FBW) ? ref_mem[rd_addr] : '0;
        if (drop) begin
            m_ovf  = 1;
            m_drop = clr_status ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
        end else if (clr_status) begin
            m_ovf = 0; m_drop = 0;
        end
        if (aev) m_aerr = 1;
        else if (clr_status) m_aerr = 0;
    endtask

    initial begin
        forever begin
            @(posedge pixel_clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Every cycle: all outputs against the model.
    initial begin
        forever begin
            @(negedge pixel_clk);
            check("rd_valid", 32'(rd_valid), 32'(m_rv2));
            check("rd_data", 32'(rd_data), 32'(m_rd2));
            check("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
            check("fifo_level", 32'(fifo_level), 32'(mq.size()));
            check("bram_en", 32'(bram_en), 32'(m_en));
            check("bram_we", 32'(bram_we), 32'(m_we));
            if (m_en) check("bram_addr", 32'(bram_addr), 32'(m_addr));
            if (m_we) check("bram_din", 32'(bram_din), 32'(m_din));
            check("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
            check("addr_err", 32'(addr_err), 32'(m_aerr));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    // Observation logs for the hand-computed checks.
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int            wc[$];
    logic [DW-1:0] rdat[$];
    int            rc[$];
    int            en_cnt = 0;
    initial begin
        forever begin
            @(negedge pixel_clk);
            if (bram_en && bram_we) begin wa.push_back(bram_addr); wd.push_back(bram_din); wc.push_back(cyc); end
            if (rd_valid) begin rdat.push_back(rd_data); rc.push_back(cyc); end
            if (bram_en) en_cnt++;
        end
    end

    task automatic nxt();
        @(negedge pixel_clk);
        #1;
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); rdat.delete(); rc.delete(); en_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 65536; i++) begin bram_mem[i] = '0; ref_mem[i] = '0; end
        bram_dout = '0;
        rd_req = 0; rd_addr = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; clr_status = 0;
        reset_n = 1;
        #1 reset_n = 0;
        repeat (3) nxt();
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_bram", 32'({bram_en, bram_we, bram_addr, bram_din}), 32'd0);
        check("rst_rd", 32'({rd_valid, rd_data}), 32'd0);
        check("rst_status", 32'({wr_overflow, addr_err, drop_cnt}), 32'd0);
        reset_n = 1;
        nxt();

        // 4 writes drain back to back in order
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_addr = 16'(i); wr_data = 18'(i + 1);
            nxt();
        end
        wr_valid = 0;
        repeat (4) nxt();
        check("t1_nwr", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                check("t1_addr", 32'(wa[i]), 32'(i));
                check("t1_data", 32'(wd[i]), 32'(i + 1));
            end
        end
        if (wc.size() == 4) check("t1_consec", 32'(wc[3] - wc[0]), 32'd3);
        check("t1_level", 32'(fifo_level), 32'd0);

        // preload then 3 back-to-back reads
        wr_valid = 1; wr_addr = 16'd100; wr_data = 18'h3F000;
        nxt();
        wr_valid = 0;
        repeat (3) nxt();
        clear_logs();
        rd_req = 1; rd_addr = 16'd100; c0 = cyc;
        repeat (3) nxt();
        rd_req = 0;
        repeat (4) nxt();
        check("t2_nrd", 32'(rc.size()), 32'd3);
        if (rc.size() == 3) begin
            check("t2_first", 32'(rc[0]), 32'(c0 + 2));
            check("t2_last", 32'(rc[2]), 32'(c0 + 4));
            for (int i = 0; i < 3; i++) check("t2_data", 32'(rdat[i]), 32'h3F000);
        end

        // reads starve writes: 4 accepted, 16 dropped, then drain
        for (int i = 0; i < 20; i++) begin
            rd_req = 1; rd_addr = 16'd5;
            wr_valid = 1; wr_addr = 16'(10 + i); wr_data = 18'(18'h100 + i);
            nxt();
        end
        check("t3_drop", 32'(drop_cnt), 32'd16);
        check("t3_ovf", 32'(wr_overflow), 32'd1);
        check("t3_level", 32'(fifo_level), 32'd4);
        check("t3_ready", 32'(wr_ready), 32'd0);
        rd_req = 0; wr_valid = 0;
        clear_logs();
        repeat (6) nxt();
        check("t3_nwr", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                check("t3_addr", 32'(wa[i]), 32'(10 + i));
                check("t3_data", 32'(wd[i]), 32'(18'h100 + i));
            end
        end
        if (wc.size() == 4) check("t3_consec", 32'(wc[3] - wc[0]), 32'd3);

        // clear, then out-of-range read and write together
        clr_status = 1;
        nxt();
        clr_status = 0;
        check("t4_clr", 32'({wr_overflow, addr_err, drop_cnt}), 32'd0);
        clear_logs();
        rd_req = 1; rd_addr = 16'd49152; wr_valid = 1; wr_addr = 16'd50000; wr_data = 18'h2AAAA;
        c0 = cyc;
        nxt();
        rd_req = 0; wr_valid = 0;
        check("t4_aerr", 32'(addr_err), 32'd1);
        check("t4_level", 32'(fifo_level), 32'd0);
        repeat (3) nxt();
        check("t4_no_en", 32'(en_cnt), 32'd0);
        check("t4_nrd", 32'(rc.size()), 32'd1);
        if (rc.size() == 1) begin
            check("t4_when", 32'(rc[0]), 32'(c0 + 2));
            check("t4_zero", 32'(rdat[0]), 32'd0);
        end

        // fill, overflow twice, then clear collides with another overflow
        for (int i = 0; i < 6; i++) begin
            rd_req = 1; rd_addr = 16'd0;
            wr_valid = 1; wr_addr = 16'(200 + i); wr_data = 18'(18'h2000 + i);
            nxt();
        end
        check("t5_pre_drop", 32'(drop_cnt), 32'd2);
        clr_status = 1;
        nxt();
        clr_status = 0; wr_valid = 0;
        check("t5_ovf", 32'(wr_overflow), 32'd1);
        check("t5_drop", 32'(drop_cnt), 32'd1);
        check("t5_aerr", 32'(addr_err), 32'd0);

        // reset in the middle of draining
        rd_req = 0;
        nxt();
        check("t6_level", 32'(fifo_level), 32'd3);
        reset_n = 0;
        #1;
        check("t6_rst_bram", 32'({bram_en, bram_we, bram_addr, bram_din}), 32'd0);
        check("t6_rst_rd", 32'({rd_valid, rd_data}), 32'd0);
        check("t6_rst_fifo", 32'({wr_ready, fifo_level}), 32'h8);
        check("t6_rst_status", 32'({wr_overflow, addr_err, drop_cnt}), 32'd0);
        repeat (2) nxt();
        reset_n = 1;
        clear_logs();
        repeat (4) nxt();
        check("t6_no_we", 32'(wa.size()), 32'd0);
        wr_valid = 1; wr_addr = 16'd300; wr_data = 18'h15555;
        nxt();
        wr_valid = 0;
        repeat (3) nxt();
        check("t6_new_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) check("t6_new_addr", 32'(wa[0]), 32'd300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
